// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel-enable divider, h/v counters,
// registered sync/bright decodes, frame pulse and delayed copies.
module vga_timing_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 4,
  parameter int PIPE_DLY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        hSync_d,
  output logic        vSync_d,
  output logic        bright_d
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic          run;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic          wrap_f;

  logic [PIPE_DLY-1:0] hs_q;
  logic [PIPE_DLY-1:0] vs_q;
  logic [PIPE_DLY-1:0] br_q;

  // run holds the divider at 0 for the first cycle after release,
  // so the first tick lands on the CLK_DIV-th cycle
  assign pix_en = run && (div == DIV_MAX);

  // next raster position; wrap_f flags the end-of-frame wrap
  always_comb begin
    h_nxt  = hCount;
    v_nxt  = vCount;
    wrap_f = 1'b0;
    if (pix_en) begin
      if (hCount == H_MAX) begin
        h_nxt = '0;
        if (vCount == V_MAX) begin
          v_nxt  = '0;
          wrap_f = 1'b1;
        end else begin
          v_nxt = vCount + 10'd1;
        end
      end else begin
        h_nxt = hCount + 10'd1;
      end
    end
  end

  // divider, counters and decodes taken from the next-state counts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run         <= 1'b0;
      div         <= '0;
      hCount      <= '0;
      vCount      <= '0;
      hSync       <= 1'b1;
      vSync       <= 1'b1;
      bright      <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        div <= (div == DIV_MAX) ? '0 : div + 1'b1;
      end
      hCount      <= h_nxt;
      vCount      <= v_nxt;
      hSync       <= !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
      vSync       <= !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
      bright      <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      frame_start <= wrap_f;
      if (wrap_f) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // free-running delay line for renderer alignment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q <= '1;
      vs_q <= '1;
      br_q <= '0;
    end else begin
      hs_q[0] <= hSync;
      vs_q[0] <= vSync;
      br_q[0] <= bright;
      for (int i = 1; i < PIPE_DLY; i++) begin
        hs_q[i] <= hs_q[i-1];
        vs_q[i] <= vs_q[i-1];
        br_q[i] <= br_q[i-1];
      end
    end
  end

  assign hSync_d  = hs_q[PIPE_DLY-1];
  assign vSync_d  = vs_q[PIPE_DLY-1];
  assign bright_d = br_q[PIPE_DLY-1];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: three builds checked every clk
// against an arithmetic raster model, with random resets.
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic        pe;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        br;
    logic        fs;
    logic [15:0] fc;
    logic        hsd;
    logic        vsd;
    logic        brd;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;

  logic [2:0] hq [3][$];

  // build A: default timing, CLK_DIV 4, PIPE_DLY 1
  logic a_pe, a_hs, a_vs, a_br, a_fs, a_hsd, a_vsd, a_brd;
  logic [9:0] a_h, a_v;
  logic [15:0] a_fc;
  vga_timing_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .pix_en(a_pe),
    .hCount(a_h), .vCount(a_v), .hSync(a_hs), .vSync(a_vs),
    .bright(a_br), .frame_start(a_fs), .frame_cnt(a_fc),
    .hSync_d(a_hsd), .vSync_d(a_vsd), .bright_d(a_brd)
  );

  // build B: small raster, CLK_DIV 3, PIPE_DLY 3
  logic b_pe, b_hs, b_vs, b_br, b_fs, b_hsd, b_vsd, b_brd;
  logic [9:0] b_h, b_v;
  logic [15:0] b_fc;
  vga_timing_ctrl #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(3), .PIPE_DLY(3)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .pix_en(b_pe),
    .hCount(b_h), .vCount(b_v), .hSync(b_hs), .vSync(b_vs),
    .bright(b_br), .frame_start(b_fs), .frame_cnt(b_fc),
    .hSync_d(b_hsd), .vSync_d(b_vsd), .bright_d(b_brd)
  );

  // build C: small raster, CLK_DIV 1, PIPE_DLY 8
  logic c_pe, c_hs, c_vs, c_br, c_fs, c_hsd, c_vsd, c_brd;
  logic [9:0] c_h, c_v;
  logic [15:0] c_fc;
  vga_timing_ctrl #(
    .H_VISIBLE(10), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(5), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .PIPE_DLY(8)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .pix_en(c_pe),
    .hCount(c_h), .vCount(c_v), .hSync(c_hs), .vSync(c_vs),
    .bright(c_br), .frame_start(c_fs), .frame_cnt(c_fc),
    .hSync_d(c_hsd), .vSync_d(c_vsd), .bright_d(c_brd)
  );

  // expected outputs at cycle tt (0 = reset cycle, 1 = first after
  // release): n pixel ticks have completed, raster is n mod total
  function automatic obs_t model(
    input int tt, input int d,
    input int hv, input int hf, input int hsw, input int hb,
    input int vv, input int vf, input int vsw, input int vb
  );
    obs_t e;
    int ht, vt, n, h, v;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (tt >= 1) begin
      n = (tt - 1) / d;
      h = n % ht;
      v = (n / ht) % vt;
      e.pe = (tt % d) == 0;
      e.h  = 10'(h);
      e.v  = 10'(v);
      e.hs = !(h >= hv + hf && h < hv + hf + hsw);
      e.vs = !(v >= vv + vf && v < vv + vf + vsw);
      e.br = (h < hv) && (v < vv);
      e.fc = 16'((n / (ht * vt)) % 65536);
      e.fs = (n > 0) && (n % (ht * vt) == 0) && ((tt - 1) % d == 0);
    end
    return e;
  endfunction

  // apply a PIPE_DLY-cycle history; reset refills it with idle values
  task automatic dly(input int k, input bit rs, input int p,
                     inout obs_t e);
    logic [2:0] cur;
    logic [2:0] old;
    cur = {e.hs, e.vs, e.br};
    if (rs) begin
      hq[k].delete();
      repeat (p) hq[k].push_back(3'b110);
    end
    hq[k].push_back(cur);
    if (hq[k].size() > p + 1) void'(hq[k].pop_front());
    old = hq[k][0];
    e.hsd = old[2];
    e.vsd = old[1];
    e.brd = old[0];
  endtask

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d t=%0d", tag, o, e, t);
    end
  endtask

  task automatic cmp(input string n, input obs_t o, input obs_t e);
    chk({n, ".pix_en"}, 32'(o.pe), 32'(e.pe));
    chk({n, ".hCount"}, 32'(o.h), 32'(e.h));
    chk({n, ".vCount"}, 32'(o.v), 32'(e.v));
    chk({n, ".hSync"}, 32'(o.hs), 32'(e.hs));
    chk({n, ".vSync"}, 32'(o.vs), 32'(e.vs));
    chk({n, ".bright"}, 32'(o.br), 32'(e.br));
    chk({n, ".frame_start"}, 32'(o.fs), 32'(e.fs));
    chk({n, ".frame_cnt"}, 32'(o.fc), 32'(e.fc));
    chk({n, ".hSync_d"}, 32'(o.hsd), 32'(e.hsd));
    chk({n, ".vSync_d"}, 32'(o.vsd), 32'(e.vsd));
    chk({n, ".bright_d"}, 32'(o.brd), 32'(e.brd));
  endtask

  int hs_fall = -1;
  int hs_rise = -1;
  int br_fall = -1;
  int v1_at   = -1;
  logic pa_hs = 1'b1;
  logic pa_br = 1'b0;
  logic [9:0] pa_v = '0;

  task automatic step();
    obs_t ea, eb, ec, oa, ob, oc;
    bit rs;
    @(posedge clk);
    #1;
    rs = !rst_n;
    if (rs) t = 0;
    else t++;
    ea = model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    eb = model(t, 3, 16, 2, 3, 2, 8, 1, 2, 1);
    ec = model(t, 1, 10, 1, 2, 1, 5, 1, 1, 1);
    dly(0, rs, 1, ea);
    dly(1, rs, 3, eb);
    dly(2, rs, 8, ec);
    oa = {a_pe, a_h, a_v, a_hs, a_vs, a_br, a_fs, a_fc,
          a_hsd, a_vsd, a_brd};
    ob = {b_pe, b_h, b_v, b_hs, b_vs, b_br, b_fs, b_fc,
          b_hsd, b_vsd, b_brd};
    oc = {c_pe, c_h, c_v, c_hs, c_vs, c_br, c_fs, c_fc,
          c_hsd, c_vsd, c_brd};
    cmp("A", oa, ea);
    cmp("B", ob, eb);
    cmp("C", oc, ec);
    if (t >= 1) begin
      if (pa_hs && !a_hs && hs_fall < 0) hs_fall = t;
      if (!pa_hs && a_hs && hs_rise < 0) hs_rise = t;
      if (pa_br && !a_br && br_fall < 0) br_fall = t;
      if (pa_v == 10'd0 && a_v == 10'd1 && v1_at < 0) v1_at = t;
    end
    pa_hs = a_hs;
    pa_br = a_br;
    pa_v  = a_v;
  endtask

  initial begin
    // reset held for 5 clks
    rst_n = 1'b0;
    repeat (5) step();
    rst_n = 1'b1;

    // first line of the default build, many frames of the small ones
    repeat (3300) step();
    chk("A.bright_fall_t", 32'(br_fall), 32'(1 + 640 * 4));
    chk("A.hsync_fall_t", 32'(hs_fall), 32'(1 + 656 * 4));
    chk("A.hsync_rise_t", 32'(hs_rise), 32'(1 + 752 * 4));
    chk("A.line_len_t", 32'(v1_at), 32'(1 + 3200));

    // random run lengths with short resets at arbitrary positions
    for (int i = 0; i < 18; i++) begin
      rst_n = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      rst_n = 1'b1;
      repeat ($urandom_range(100, 3000)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Raster timing generator for the 640x480@60 Hz VGA path; sits directly upstream of the block/ball/paddle renderers.
- Divides the 100 MHz system clock into a pixel-enable tick and produces hCount/vCount, hSync/vSync, bright and a frame pulse.
- Also provides pipeline-delayed copies of sync/bright, aligned to renderers that register their pixel outputs one or more clk cycles after hCount/vCount.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (min 1)
- PIPE_DLY, 1, clk-cycle delay applied to the *_d outputs (min 1, max 8)

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous reset, active-low
- pix_en  out  1  one-clk pulse once every CLK_DIV clks; counters advance on it
- hCount  out  10  horizontal position, 0..H_TOTAL-1 (H_TOTAL=800)
- vCount  out  10  vertical position, 0..V_TOTAL-1 (V_TOTAL=525)
- hSync  out  1  horizontal sync, active-low
- vSync  out  1  vertical sync, active-low
- bright  out  1  high when hCount<H_VISIBLE and vCount<V_VISIBLE
- frame_start  out  1  one-clk pulse on the first clk at (0,0) of each new frame
- frame_cnt  out  16  frames completed since reset, wraps 65535->0
- hSync_d  out  1  hSync delayed PIPE_DLY clks
- vSync_d  out  1  vSync delayed PIPE_DLY clks
- bright_d  out  1  bright delayed PIPE_DLY clks

Behaviour:
- Single clock domain; every flop is reset synchronously when rst_n=0 at a clk posedge.
- Reset values:
  - div counter=0, pix_en=0, hCount=0, vCount=0, frame_start=0, frame_cnt=0.
  - hSync=1, vSync=1, bright=0.
  - All delay-line stages: sync=1, bright=0, so hSync_d=1, vSync_d=1, bright_d=0.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 exactly in the clk cycle where div==CLK_DIV-1.
  - First pix_en is the CLK_DIV-th cycle after reset release.
  - CLK_DIV=1 gives pix_en=1 on every cycle after release.
- Counters advance only on the clk edge ending a pix_en=1 cycle; otherwise they hold.
  - hCount: +1, wraps H_TOTAL-1 -> 0.
  - vCount: +1 only when hCount wraps; wraps V_TOTAL-1 -> 0.
  - Each (hCount,vCount) value is held exactly CLK_DIV clks.
- Decodes are registered from the next-state counters, so they are cycle-aligned with hCount/vCount; there is no skew between counts and decodes.
  - hSync=0 iff H_VISIBLE+H_FP <= hCount < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vSync=0 iff V_VISIBLE+V_FP <= vCount < V_VISIBLE+V_FP+V_SYNC (490..491).
  - bright per the port definition. On the first cycle after reset release bright=1, since the counts are (0,0).
- frame_start:
  - High for exactly one clk: the first cycle where the counters read (0,0) after the (799,524) -> (0,0) wrap.
  - Not asserted on the (0,0) immediately following reset.
  - frame_cnt increments on that same edge, so it is visible alongside frame_start.
- Delay line:
  - PIPE_DLY-stage shift register clocked every clk, not gated by pix_en.
  - hSync_d(t)=hSync(t-PIPE_DLY); same rule for vSync_d and bright_d.
- Reset mid-operation (any line or frame position): next cycle all outputs return to their reset values and the raster restarts at (0,0). frame_cnt returns to 0.
- Widths: H_TOTAL and V_TOTAL must be <=1024. Comparisons are unsigned, with no overflow at the wrap values.

Test Plan:
- Reset held 5 clks, then released:
  - During reset: hSync=1, vSync=1, bright=0, counts 0, frame_cnt=0.
  - Cycle 1 after release: bright=1.
  - Cycles 1..3: pix_en=0. Cycle 4: pix_en=1. Cycle 5: hCount=1.
- Free-run one line:
  - hSync falls on the first clk of hCount=656 and rises on the first clk of hCount=752.
  - bright falls on the first clk of hCount=640.
  - Line length is 3200 clks; vCount increments on the hCount 799->0 edge.
- Free-run one frame:
  - vSync is low for vCount 490..491 (6400 clks).
  - frame_start pulses once, 1,680,000 clks after the first (0,0) following reset; frame_cnt=1 on that cycle.
  - After 3 frames, frame_cnt=3.
- Delay outputs with PIPE_DLY=1 and PIPE_DLY=3: hSync_d/vSync_d/bright_d equal hSync/vSync/bright shifted by exactly 1 and 3 clks across the bright and hSync edges.
- Reset asserted at hCount=700, vCount=300 for 1 clk:
  - Next cycle: counts are (0,0), hSync=1, frame_cnt=0, delay line cleared.
  - No frame_start pulse at the restart.
- CLK_DIV=1 build: pix_en is constant 1 after release, and one line is 800 clks.
